// File: rtl/instruction_encoder.sv
// instruction_encoder: packs RV32I fields into a 32-bit word behind a 2-entry (out + skid) valid/ready buffer.
// Optional IMM_RANGE_CHECK_EN flags immediates that do not fit the format's range.
module instruction_encoder #(
  parameter int INST_WIDTH = 32,
  parameter int OPCODE     = 7,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [OPCODE-1:0]     opcode_i,
  input  logic [4:0]            rd_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic [INST_WIDTH-1:0] imm_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic                  err_o,
  output logic [ERR_CNT_W-1:0]  err_count_o
);
  localparam logic [OPCODE-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE-1:0] OP_ALUI   = 7'b0010011;
  localparam logic [OPCODE-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPCODE-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE-1:0] OP_ALU    = 7'b0110011;
  localparam logic [OPCODE-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE-1:0] OP_JAL    = 7'b1101111;
`ifdef IMM_RANGE_CHECK_EN
  localparam bit RCHK = 1'b1;
`else
  localparam bit RCHK = 1'b0;
`endif

  logic [INST_WIDTH-1:0] enc_inst, out_inst_q, out_inst_d, sk_inst_q, sk_inst_d;
  logic                  enc_err, out_v_q, out_v_d, out_err_q, out_err_d, sk_v_q, sk_v_d, sk_err_q, sk_err_d;
  logic [ERR_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  acc, load_out;
  logic [31:0]           imm;

  assign imm = imm_i;

  always_comb begin
    enc_inst = 32'h0000_0013;
    enc_err  = 1'b1;
    case (opcode_i)
      OP_ALU: begin
        enc_inst = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        enc_err  = 1'b0;
      end
      OP_ALUI, OP_LOAD, OP_JALR: begin
        enc_inst = {imm[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        enc_err  = RCHK && (imm != {{20{imm[11]}}, imm[11:0]});
      end
      OP_STORE: begin
        enc_inst = {imm[11:5], rs2_i, rs1_i, funct3_i, imm[4:0], opcode_i};
        enc_err  = RCHK && (imm != {{20{imm[11]}}, imm[11:0]});
      end
      OP_BRANCH: begin
        enc_inst = {imm[12], imm[10:5], rs2_i, rs1_i, funct3_i, imm[4:1], imm[11], opcode_i};
        enc_err  = RCHK && ((imm != {{19{imm[12]}}, imm[12:0]}) || imm[0]);
      end
      OP_LUI, OP_AUIPC: begin
        enc_inst = {imm[31:12], rd_i, opcode_i};
        enc_err  = RCHK && (|imm[11:0]);
      end
      OP_JAL: begin
        enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd_i, opcode_i};
        enc_err  = RCHK && ((imm != {{11{imm[20]}}, imm[20:0]}) || imm[0]);
      end
      default: begin
        enc_inst = 32'h0000_0013;
        enc_err  = 1'b1;
      end
    endcase
  end

  // skid only ever holds a beat while the output reg is full, so it drains first
  assign acc      = valid_i && !sk_v_q;
  assign load_out = !out_v_q || ready_i;

  always_comb begin
    out_v_d    = load_out ? (sk_v_q || acc) : out_v_q;
    out_inst_d = !load_out ? out_inst_q : sk_v_q ? sk_inst_q : acc ? enc_inst : out_inst_q;
    out_err_d  = !load_out ? out_err_q : sk_v_q ? sk_err_q : acc ? enc_err : out_err_q;
    sk_v_d     = !load_out && (sk_v_q || acc);
    sk_inst_d  = (acc && !load_out) ? enc_inst : sk_inst_q;
    sk_err_d   = (acc && !load_out) ? enc_err : sk_err_q;
    cnt_d      = (acc && enc_err && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v_q    <= 1'b0;
      out_inst_q <= '0;
      out_err_q  <= 1'b0;
      sk_v_q     <= 1'b0;
      sk_inst_q  <= '0;
      sk_err_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      out_v_q    <= out_v_d;
      out_inst_q <= out_inst_d;
      out_err_q  <= out_err_d;
      sk_v_q     <= sk_v_d;
      sk_inst_q  <= sk_inst_d;
      sk_err_q   <= sk_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ready_o     = !sk_v_q;
  assign valid_o     = out_v_q;
  assign inst_o      = out_inst_q;
  assign err_o       = out_err_q;
  assign err_count_o = cnt_q;
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed + random stimulus against a queue-based reference of the encoder.
module tb_instruction_encoder;
  logic        clk = 1'b0, rst = 1'b1, valid_i = 1'b0, ready_i = 1'b0;
  logic        ready_o, valid_o, err_o;
  logic [6:0]  opcode_i = '0, funct7_i = '0;
  logic [4:0]  rd_i = '0, rs1_i = '0, rs2_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] imm_i = '0, inst_o;
  logic [7:0]  err_count_o;

  instruction_encoder dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
    .valid_o(valid_o), .ready_i(ready_i), .inst_o(inst_o), .err_o(err_o),
    .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cnt_m = 0;
  logic [32:0] q[$];
  logic [32:0] prev_out;
  bit          prev_stall = 0;
`ifdef IMM_RANGE_CHECK_EN
  localparam bit RCHK = 1;
`else
  localparam bit RCHK = 0;
`endif

  function automatic logic [32:0] ref_enc(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                          logic [2:0] f3, logic [6:0] f7, logic [31:0] imm);
    int unsigned base = op | (32'(f3) << 12) | (32'(rs1) << 15);
    int si = $signed(imm);
    int unsigned w;
    bit bad;
    case (op)
      7'h33: begin w = base | (32'(rd) << 7) | (32'(rs2) << 20) | (32'(f7) << 25); bad = 0; end
      7'h13, 7'h03, 7'h67: begin
        w = base | (32'(rd) << 7) | ((imm & 32'hFFF) << 20); bad = si < -2048 || si > 2047;
      end
      7'h23: begin
        w = base | ((imm & 31) << 7) | (32'(rs2) << 20) | (((imm >> 5) & 32'h7F) << 25);
        bad = si < -2048 || si > 2047;
      end
      7'h63: begin
        w = base | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 15) << 8) | (32'(rs2) << 20)
            | (((imm >> 5) & 63) << 25) | (((imm >> 12) & 1) << 31);
        bad = si < -4096 || si > 4095 || (imm % 2 != 0);
      end
      7'h37, 7'h17: begin w = op | (32'(rd) << 7) | (imm & 32'hFFFF_F000); bad = (imm & 32'hFFF) != 0; end
      7'h6F: begin
        w = op | (32'(rd) << 7) | (imm & 32'h000F_F000) | (((imm >> 11) & 1) << 20)
            | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 1) << 31);
        bad = si < -(1 << 20) || si >= (1 << 20) || (imm % 2 != 0);
      end
      default: return {1'b1, 32'h13};
    endcase
    return {RCHK && bad, w};
  endfunction

  task automatic chk(string tag, logic [32:0] obs, logic [32:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks current outputs against the model, drives one cycle of stimulus, then advances the model.
  task automatic step(bit r, bit v, logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                      logic [2:0] f3, logic [6:0] f7, logic [31:0] imm, bit rdy);
    chk("valid_o", 33'(valid_o), 33'(q.size() != 0));
    chk("ready_o", 33'(ready_o), 33'(q.size() < 2));
    chk("err_count_o", 33'(err_count_o), 33'(cnt_m));
    if (q.size() != 0) chk("inst_err", {err_o, inst_o}, q[0]);
    if (prev_stall) chk("stall_hold", {err_o, inst_o}, prev_out);
    rst = r; valid_i = v; opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
    funct3_i = f3; funct7_i = f7; imm_i = imm; ready_i = rdy;
    prev_stall = !r && q.size() != 0 && !rdy;
    prev_out = {err_o, inst_o};
    if (r) begin
      q.delete(); cnt_m = 0;
    end else begin
      bit acc = v && q.size() < 2;
      logic [32:0] e = ref_enc(op, rd, rs1, rs2, f3, f7, imm);
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        if (e[32] && cnt_m < 255) cnt_m++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rnd_step(bit err_heavy);
    logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    logic [6:0] op = err_heavy ? 7'($urandom) : ops[$urandom_range(0, 9)];
    logic [31:0] imm = $urandom;
    if ($urandom_range(0, 1) == 1) imm = 32'($signed(imm[13:0])) & ~32'($urandom_range(0, 1));
    step(0, $urandom_range(0, 3) != 0, op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
         7'($urandom), imm, $urandom_range(0, 2) != 0);
  endtask

  initial begin
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("rst_valid_o", 33'(valid_o), 33'(0));
    chk("rst_inst_o", 33'(inst_o), 33'(0));
    chk("rst_err_o", 33'(err_o), 33'(0));
    chk("rst_err_count", 33'(err_count_o), 33'(0));
    chk("rst_ready_o", 33'(ready_o), 33'(1));
    step(0, 1, 7'h23, 0, 16, 15, 0, 0, 32'hFFFF_F800, 1);
    chk("store", {err_o, valid_o, inst_o}, {2'b01, 32'h80F8_0023});
    step(0, 1, 7'h37, 1, 0, 0, 0, 0, 32'h0001_7000, 1);
    chk("lui", {err_o, inst_o}, {1'b0, 32'h0001_70B7});
    step(0, 1, 7'h6F, 4, 0, 0, 0, 0, 32'h0000_00E8, 1);
    chk("jal", {err_o, inst_o}, {1'b0, 32'h0E80_026F});
    step(0, 1, 7'h63, 0, 2, 4, 0, 0, 32'hFFFF_FFE8, 1);
    chk("branch", {err_o, inst_o}, {1'b0, 32'hFE41_04E3});
    step(0, 1, 7'h63, 0, 0, 0, 0, 0, 32'h0000_1001, 1);
    chk("branch_range", {err_o, inst_o}, {RCHK, 32'h8000_0063});
    chk("branch_range_cnt", 33'(err_count_o), 33'(RCHK));
    step(0, 1, 7'h7F, 3, 3, 3, 3, 3, 32'h1234_5678, 1);
    chk("unknown_op", {err_o, inst_o}, {1'b1, 32'h0000_0013});
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 7'h33, 1, 2, 3, 0, 7'h20, 0, 0);
    step(0, 1, 7'h33, 4, 5, 6, 1, 7'h00, 0, 0);
    chk("bp_full", 33'(ready_o), 33'(0));
    step(0, 1, 7'h33, 7, 8, 9, 2, 7'h00, 0, 0);
    chk("bp_still_full", 33'(ready_o), 33'(0));
    step(0, 1, 7'h33, 7, 8, 9, 2, 7'h00, 0, 1);
    step(0, 1, 7'h33, 7, 8, 9, 2, 7'h00, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 7'h13, 1, 1, 0, 0, 0, 32'h5, 0);
    step(0, 1, 7'h13, 2, 2, 0, 0, 0, 32'h6, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("midrst_valid_o", 33'(valid_o), 33'(0));
    chk("midrst_err_count", 33'(err_count_o), 33'(0));
    chk("midrst_ready_o", 33'(ready_o), 33'(1));
    for (int i = 0; i < 1500; i++) rnd_step(0);
    for (int i = 0; i < 400; i++) rnd_step(1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("drained", 33'(q.size()), 33'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
